// File: rtl/led_spi_master.sv
// SPI mode-3 master (CPOL=1, CPHA=1, MSB first) feeding led_spi_slave: serialises
// valid/ready command words onto chip_select/sclk/mosi and captures miso into rx_data.
module led_spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  sclk,
  output logic                  chip_select,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_WAIT,
    ST_HOLD,
    ST_DESELECT
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  last_q, last_d;
  logic                  cs_q, cs_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ready_q, ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

  logic                  phase_done;
  logic [DATA_WIDTH-1:0] tx_next;

  assign phase_done = (div_q == '0);
  assign tx_next    = tx_shift_q << 1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      last_q     <= 1'b0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      last_q     <= last_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    last_d     = last_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ready_d    = ready_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;

    case (state_q)
      ST_IDLE, ST_WAIT: begin
        ready_d = 1'b1;
        if (tx_valid && ready_q) begin
          tx_shift_d = tx_data;
          last_d     = tx_last;
          cs_d       = 1'b0;
          ready_d    = 1'b0;
          bit_d      = '0;
          div_d      = DIV_LOAD;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_done) begin
          sclk_d  = 1'b0;
          mosi_d  = tx_shift_q[DATA_WIDTH-1];
          div_d   = DIV_LOAD;
          state_d = ST_SHIFT_LO;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SHIFT_LO: begin
        // On a closing word the final high phase doubles as the chip_select hold time.
        if (phase_done) begin
          sclk_d     = 1'b1;
          rx_shift_d = DATA_WIDTH'({rx_shift_q, miso});
          div_d      = DIV_LOAD;
          state_d    = (bit_q == BIT_LAST && last_q) ? ST_HOLD : ST_SHIFT_HI;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (phase_done) begin
          if (bit_q == BIT_LAST) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            ready_d    = 1'b1;
            state_d    = ST_WAIT;
          end else begin
            bit_d      = bit_q + 1'b1;
            tx_shift_d = tx_next;
            mosi_d     = tx_next[DATA_WIDTH-1];
            sclk_d     = 1'b0;
            div_d      = DIV_LOAD;
            state_d    = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_done) begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          cs_d       = 1'b1;
          mosi_d     = 1'b0;
          div_d      = DIV_LOAD;
          state_d    = ST_DESELECT;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ST_DESELECT: begin
        if (phase_done) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_ready    = ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign sclk        = sclk_q;
  assign chip_select = cs_q;
  assign mosi        = mosi_q;

endmodule

// File: tb/tb_led_spi_master.sv
// Bench for led_spi_master: one instance at CLK_DIV=2 and one at CLK_DIV=1, checked
// against a word-level model of mode-3 framing and its cycle timing.
module tb_led_spi_master;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] txData [2];
  logic [W-1:0] rxData [2];
  logic [1:0]   txLast, txValid, txReady, rxValid, sclkV, csV, mosiV, misoV;
  int           misoSel [2];

  int tests = 0;
  int failed = 0;

  led_spi_master #(.DATA_WIDTH(W), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .tx_data(txData[0]), .tx_last(txLast[0]),
    .tx_valid(txValid[0]), .tx_ready(txReady[0]), .rx_data(rxData[0]),
    .rx_valid(rxValid[0]), .sclk(sclkV[0]), .chip_select(csV[0]),
    .mosi(mosiV[0]), .miso(misoV[0])
  );

  led_spi_master #(.DATA_WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(txData[1]), .tx_last(txLast[1]),
    .tx_valid(txValid[1]), .tx_ready(txReady[1]), .rx_data(rxData[1]),
    .rx_valid(rxValid[1]), .sclk(sclkV[1]), .chip_select(csV[1]),
    .mosi(mosiV[1]), .miso(misoV[1])
  );

  // miso source per instance: 0 = loopback, 1 = inverted loopback, 2 = tied high
  always_comb begin
    misoV = '0;
    for (int k = 0; k < 2; k++) begin
      case (misoSel[k])
        0:       misoV[k] = mosiV[k];
        1:       misoV[k] = ~mosiV[k];
        default: misoV[k] = 1'b1;
      endcase
    end
  end

  function automatic int divOf(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Bus monitor: records SPI events with their cycle numbers for the checks below
  int   riseCnt [2] = '{0, 0};
  int   risesSinceRx [2] = '{0, 0};
  int   fallsSinceCs [2] = '{0, 0};
  int   lastRiseCyc [2] = '{0, 0};
  int   lastFallCyc [2] = '{0, 0};
  int   firstFallCyc [2] = '{0, 0};
  int   csFallCyc [2] = '{0, 0};
  int   csFallCnt [2] = '{0, 0};
  int   csRiseCyc [2] = '{0, 0};
  int   readyRiseCyc [2] = '{0, 0};
  int   readyInFrame [2] = '{0, 0};
  int   rxCnt [2] = '{0, 0};
  int   mosiBad [2] = '{0, 0};
  int   periodBad [2] = '{0, 0};
  int   lowBad [2] = '{0, 0};
  logic mosiArr [2][512];
  logic [W-1:0] rxVals [2][64];
  int   rxCyc [2][64];
  logic [1:0] prevCs = 2'b11, prevSclk = 2'b11, prevMosi = 2'b00, prevReady = 2'b00;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (prevCs[k] === 1'b1 && csV[k] === 1'b0) begin
        csFallCyc[k] = cyc;
        csFallCnt[k]++;
        fallsSinceCs[k] = 0;
      end
      if (prevCs[k] === 1'b0 && csV[k] === 1'b1) csRiseCyc[k] = cyc;
      if (csV[k] === 1'b0 && prevSclk[k] === 1'b1 && sclkV[k] === 1'b0) begin
        if (fallsSinceCs[k] == 0) firstFallCyc[k] = cyc;
        fallsSinceCs[k]++;
        lastFallCyc[k] = cyc;
      end
      if (csV[k] === 1'b0 && prevSclk[k] === 1'b0 && sclkV[k] === 1'b1) begin
        if (cyc - lastFallCyc[k] != divOf(k)) lowBad[k]++;
        if (risesSinceRx[k] > 0 && cyc - lastRiseCyc[k] != 2 * divOf(k)) periodBad[k]++;
        mosiArr[k][riseCnt[k] % 512] = mosiV[k];
        riseCnt[k]++;
        risesSinceRx[k]++;
        lastRiseCyc[k] = cyc;
      end
      if (csV[k] === 1'b0 && prevCs[k] === 1'b0 && mosiV[k] !== prevMosi[k] &&
          !(prevSclk[k] === 1'b1 && sclkV[k] === 1'b0)) mosiBad[k]++;
      if (txReady[k] === 1'b1 && prevReady[k] !== 1'b1) readyRiseCyc[k] = cyc;
      if (txReady[k] === 1'b1 && csV[k] === 1'b0) readyInFrame[k]++;
      if (rxValid[k] === 1'b1) begin
        rxVals[k][rxCnt[k] % 64] = rxData[k];
        rxCyc[k][rxCnt[k] % 64] = cyc;
        rxCnt[k]++;
        risesSinceRx[k] = 0;
      end
      if (reset === 1'b0) risesSinceRx[k] = 0;
      prevCs[k] = csV[k];
      prevSclk[k] = sclkV[k];
      prevMosi[k] = mosiV[k];
      prevReady[k] = txReady[k];
    end
  end

  // Reference model: expected received word for a given miso source
  function automatic logic [W-1:0] modelRx(input int sel, input logic [W-1:0] d);
    if (sel == 0) return d;
    if (sel == 1) return ~d;
    return '1;
  endfunction

  function automatic logic [W-1:0] mosiWord(input int k, input int base);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) w = {w[W-2:0], mosiArr[k][(base + i) % 512]};
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the falling edge, once the monitor has updated
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input logic [W-1:0] data, input logic last,
                               input logic holdValid, output int accCyc);
    int n = 0;
    tick();
    txData[k] = data;
    txLast[k] = last;
    txValid[k] = 1'b1;
    while (txReady[k] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("accept_timeout", 64'(n < 400), 64'd1);
    tick();
    accCyc = cyc;
    if (!holdValid) txValid[k] = 1'b0;
    txData[k] = W'($urandom);
  endtask

  task automatic waitIdle(input int k);
    int n = 0;
    while (!(txReady[k] === 1'b1 && csV[k] === 1'b1) && n < 400) begin
      tick();
      n++;
    end
    checkOutput("idle_timeout", 64'(n < 400), 64'd1);
  endtask

  task automatic waitRx(input int k, input int target);
    int n = 0;
    while (rxCnt[k] < target && n < 400) begin
      tick();
      n++;
    end
    checkOutput("rx_timeout", 64'(n < 400), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0, acc1, base, rxBase, csBase, rdyBase, idleBad, n, sel;
    logic [W-1:0] d;
    logic lst;

    txData[0] = '0;
    txData[1] = '0;
    txLast = '0;
    txValid = '0;
    misoSel[0] = 0;
    misoSel[1] = 2;

    // Reset values on both instances
    reset = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_cs", 64'(csV[k]), 64'd1);
      checkOutput("rst_sclk", 64'(sclkV[k]), 64'd1);
      checkOutput("rst_mosi", 64'(mosiV[k]), 64'd0);
      checkOutput("rst_tx_ready", 64'(txReady[k]), 64'd0);
      checkOutput("rst_rx_valid", 64'(rxValid[k]), 64'd0);
      checkOutput("rst_rx_data", 64'(rxData[k]), 64'd0);
    end
    reset = 1'b1;
    tick();
    checkOutput("rst_ready_rise", 64'(txReady), 64'd3);

    // Single word 0xA5, closing, loopback
    misoSel[0] = 0;
    base = riseCnt[0];
    rxBase = rxCnt[0];
    applyStimulus(0, 8'hA5, 1'b1, 1'b0, acc0);
    checkOutput("t1_cs_fall_on_accept", 64'(csFallCyc[0] - acc0), 64'd0);
    waitIdle(0);
    checkOutput("t1_rises", 64'(riseCnt[0] - base), 64'(W));
    checkOutput("t1_mosi", 64'(mosiWord(0, base)), 64'hA5);
    checkOutput("t1_rx_count", 64'(rxCnt[0] - rxBase), 64'd1);
    checkOutput("t1_rx_data", 64'(rxVals[0][rxBase % 64]), 64'hA5);
    checkOutput("t1_rx_latency", 64'(rxCyc[0][rxBase % 64] - csFallCyc[0]), 64'((2 * W + 1) * 2));
    checkOutput("t1_first_fall", 64'(firstFallCyc[0] - csFallCyc[0]), 64'd2);
    checkOutput("t1_hold", 64'(csRiseCyc[0] - lastRiseCyc[0]), 64'd2);
    checkOutput("t1_deselect", 64'(readyRiseCyc[0] - csRiseCyc[0]), 64'd2);
    checkOutput("t1_rx_data_held", 64'(rxData[0]), 64'hA5);

    // Two-word frame with tx_valid held: second word waits out the first (back-pressure)
    base = riseCnt[0];
    rxBase = rxCnt[0];
    csBase = csFallCnt[0];
    rdyBase = readyInFrame[0];
    applyStimulus(0, 8'h01, 1'b0, 1'b1, acc0);
    applyStimulus(0, 8'h02, 1'b1, 1'b0, acc1);
    waitIdle(0);
    checkOutput("t2_pitch", 64'(acc1 - acc0), 64'((2 * W + 1) * 2 + 1));
    checkOutput("t2_cs_falls", 64'(csFallCnt[0] - csBase), 64'd1);
    checkOutput("t2_rises", 64'(riseCnt[0] - base), 64'(2 * W));
    checkOutput("t2_rx_count", 64'(rxCnt[0] - rxBase), 64'd2);
    checkOutput("t2_rx0", 64'(rxVals[0][rxBase % 64]), 64'h01);
    checkOutput("t2_rx1", 64'(rxVals[0][(rxBase + 1) % 64]), 64'h02);
    checkOutput("t2_mosi0", 64'(mosiWord(0, base)), 64'h01);
    checkOutput("t2_mosi1", 64'(mosiWord(0, base + W)), 64'h02);
    checkOutput("t2_ready_in_frame", 64'(readyInFrame[0] - rdyBase), 64'd1);

    // Reset after the third sclk rise aborts the word
    rxBase = rxCnt[0];
    base = riseCnt[0];
    applyStimulus(0, 8'h5A, 1'b1, 1'b0, acc0);
    n = 0;
    while (riseCnt[0] - base < 3 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("t3_rise_timeout", 64'(n < 200), 64'd1);
    reset = 1'b0;
    tick();
    checkOutput("t3_cs", 64'(csV[0]), 64'd1);
    checkOutput("t3_sclk", 64'(sclkV[0]), 64'd1);
    checkOutput("t3_mosi", 64'(mosiV[0]), 64'd0);
    checkOutput("t3_rx_valid", 64'(rxValid[0]), 64'd0);
    checkOutput("t3_tx_ready", 64'(txReady[0]), 64'd0);
    reset = 1'b1;
    repeat (60) tick();
    checkOutput("t3_no_rx", 64'(rxCnt[0] - rxBase), 64'd0);
    base = riseCnt[0];
    rxBase = rxCnt[0];
    applyStimulus(0, 8'h3C, 1'b1, 1'b0, acc0);
    waitIdle(0);
    checkOutput("t3_fresh_rx_count", 64'(rxCnt[0] - rxBase), 64'd1);
    checkOutput("t3_fresh_rx", 64'(rxVals[0][rxBase % 64]), 64'h3C);
    checkOutput("t3_fresh_mosi", 64'(mosiWord(0, base)), 64'h3C);

    // CLK_DIV=1 instance, miso tied high, 0xFF then 0x00 back to back
    base = riseCnt[1];
    rxBase = rxCnt[1];
    applyStimulus(1, 8'hFF, 1'b0, 1'b1, acc0);
    applyStimulus(1, 8'h00, 1'b1, 1'b0, acc1);
    waitIdle(1);
    checkOutput("t4_rises", 64'(riseCnt[1] - base), 64'(2 * W));
    checkOutput("t4_mosi0", 64'(mosiWord(1, base)), 64'hFF);
    checkOutput("t4_mosi1", 64'(mosiWord(1, base + W)), 64'h00);
    checkOutput("t4_rx0", 64'(rxVals[1][rxBase % 64]), 64'hFF);
    checkOutput("t4_rx1", 64'(rxVals[1][(rxBase + 1) % 64]), 64'hFF);
    checkOutput("t4_pitch", 64'(acc1 - acc0), 64'(2 * W + 2));
    checkOutput("t4_rx_latency", 64'(rxCyc[1][rxBase % 64] - csFallCyc[1]), 64'(2 * W + 1));
    checkOutput("t4_hold", 64'(csRiseCyc[1] - lastRiseCyc[1]), 64'd1);

    // Open frame parked in WAIT for 100 cycles, then closed by a last word
    misoSel[0] = 0;
    base = riseCnt[0];
    rxBase = rxCnt[0];
    csBase = csFallCnt[0];
    applyStimulus(0, 8'hF0, 1'b0, 1'b0, acc0);
    waitRx(0, rxBase + 1);
    tick();
    idleBad = 0;
    repeat (100) begin
      tick();
      if (csV[0] !== 1'b0 || sclkV[0] !== 1'b1 || txReady[0] !== 1'b1) idleBad++;
    end
    checkOutput("t5_wait_stable", 64'(idleBad), 64'd0);
    checkOutput("t5_rx0", 64'(rxVals[0][rxBase % 64]), 64'hF0);
    applyStimulus(0, 8'h0F, 1'b1, 1'b0, acc1);
    waitIdle(0);
    checkOutput("t5_rx1", 64'(rxVals[0][(rxBase + 1) % 64]), 64'h0F);
    checkOutput("t5_mosi", 64'({mosiWord(0, base), mosiWord(0, base + W)}), 64'hF00F);
    checkOutput("t5_cs_falls", 64'(csFallCnt[0] - csBase), 64'd1);
    checkOutput("t5_hold", 64'(csRiseCyc[0] - lastRiseCyc[0]), 64'd2);

    // Randomized words with random framing and miso source
    for (int i = 0; i < 6; i++) begin
      d = W'($urandom);
      lst = (i == 5) ? 1'b1 : 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 1);
      misoSel[0] = sel;
      base = riseCnt[0];
      rxBase = rxCnt[0];
      applyStimulus(0, d, lst, 1'b0, acc0);
      waitRx(0, rxBase + 1);
      checkOutput("rand_rx", 64'(rxVals[0][rxBase % 64]), 64'(modelRx(sel, d)));
      checkOutput("rand_mosi", 64'(mosiWord(0, base)), 64'(d));
      if (lst) begin
        waitIdle(0);
        checkOutput("rand_hold", 64'(csRiseCyc[0] - lastRiseCyc[0]), 64'd2);
      end
    end

    // Whole-run waveform rules: 50% duty, fixed period, mosi only moves on sclk falls
    for (int k = 0; k < 2; k++) begin
      checkOutput("period", 64'(periodBad[k]), 64'd0);
      checkOutput("low_phase", 64'(lowBad[k]), 64'd0);
      checkOutput("mosi_stable", 64'(mosiBad[k]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/led_spi_master.md
# led_spi_master

SPI master that serialises parallel command words into the chip_select / SCLK / MOSI stream consumed by `led_spi_slave`, and captures the slave's MISO reply. It sits directly upstream of the LED slave. Firmware or test logic pushes words through a valid/ready port, and the block generates SPI mode 3 framing (CPOL=1, CPHA=1, MSB first). A `tx_last` flag chooses whether chip_select stays low between words or the frame closes.

## Interface
- `DATA_WIDTH`, default 8: bits per SPI word; must match the slave.
- `CLK_DIV`, default 2: system `clk` cycles per SCLK half-period; must be ≥1.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low. Asserted when 0 and sampled on the `clk` rising edge.
- `tx_data` in DATA_WIDTH: word to transmit.
- `tx_last` in 1: sampled with `tx_data`; 1 = deassert chip_select after this word.
- `tx_valid` in 1: word offered.
- `tx_ready` out 1: block accepts a word on a `clk` edge where `tx_valid && tx_ready`.
- `rx_data` out DATA_WIDTH: word shifted in from `miso`; valid while `rx_valid`=1, otherwise holds its last value.
- `rx_valid` out 1: one-cycle pulse per completed word.
- `sclk` out 1: SPI clock; idles high.
- `chip_select` out 1: active-low slave select.
- `mosi` out 1: serial data to slave.
- `miso` in 1: serial data from slave.

## Operation
- All outputs are registered. Reset values:
  - `chip_select`=1, `sclk`=1, `mosi`=0
  - `tx_ready`=0 for the reset cycle, then 1 in IDLE
  - `rx_valid`=0, `rx_data`=0
- FSM states: IDLE, SETUP, SHIFT_LO, SHIFT_HI, WAIT, HOLD, DESELECT. A down-counter `div_cnt` times each phase at CLK_DIV cycles. A bit counter runs 0..DATA_WIDTH-1.
- IDLE: `tx_ready`=1, `chip_select`=1, `sclk`=1.
  - On accept, latch `tx_data` into the TX shift register and latch `tx_last`.
  - Drive `chip_select`=0 and go to SETUP.
- SETUP: CLK_DIV cycles with `chip_select`=0 and `sclk`=1, then go to SHIFT_LO.
- SHIFT_LO (falling edge):
  - On entry, `sclk`=0 and `mosi`=TX shift register MSB.
  - After CLK_DIV cycles, go to SHIFT_HI.
- SHIFT_HI (rising edge):
  - On entry, `sclk`=1 and `miso` is shifted into the RX register LSB.
  - After CLK_DIV cycles, either shift TX left and go to SHIFT_LO for the next bit, or finish the word after bit DATA_WIDTH-1.
- Word completion:
  - `rx_data` is updated and `rx_valid`=1 for exactly one cycle.
  - If latched last=0, go to WAIT. If last=1, go to HOLD.
- WAIT:
  - `chip_select` stays 0, `sclk`=1, `mosi` holds its value, `tx_ready`=1.
  - On accept, go to SETUP without any chip_select pulse.
  - WAIT lasts indefinitely; there is no timeout.
- HOLD: CLK_DIV cycles with `chip_select`=0 and `sclk`=1. Then drive `chip_select`=1 and `mosi`=0, and go to DESELECT.
- DESELECT: CLK_DIV cycles with `chip_select`=1 and `tx_ready`=0, then go to IDLE.
- `tx_ready`=0 in SETUP, SHIFT_LO, SHIFT_HI, HOLD and DESELECT. `tx_valid` is ignored in those states, and `tx_data` may change freely.
- `rx_valid` and `tx_ready` may be high in the same cycle (entry to WAIT). An accept in that cycle is legal and goes to SETUP.
- Reset mid-word:
  - On the next edge, all outputs return to reset values; `chip_select` rises immediately.
  - The partial RX word is discarded and no `rx_valid` is issued.
  - The latched last flag is cleared.

## Timing
- Accept edge → `chip_select` low on the same edge (registered output, visible the next cycle).
- `chip_select` fall → first `sclk` fall: CLK_DIV cycles.
- SCLK period: 2·CLK_DIV cycles; duty cycle 50%.
- `mosi` changes only on `sclk` falling edges. The slave samples it on the rising edge, CLK_DIV cycles later.
- `chip_select` fall → `rx_valid` pulse: (2·DATA_WIDTH+1)·CLK_DIV cycles.
- Back-to-back words (last=0, `tx_valid` held high): WAIT lasts 1 cycle. Word-to-word pitch is (2·DATA_WIDTH+1)·CLK_DIV + 1 cycles.
- Final `sclk` rise → `chip_select` rise: CLK_DIV cycles (HOLD).
- Minimum `chip_select` high time before the next frame: CLK_DIV cycles (DESELECT), plus the IDLE accept cycle.
- CLK_DIV=1 is legal: SCLK is `clk`/2, and every phase lasts a single cycle.

## Test plan
- **Single word.** DATA_WIDTH=8, CLK_DIV=2, send 0xA5 with last=1 and `miso` looped to `mosi`.
  - `mosi` = 1,0,1,0,0,1,0,1 at the 8 `sclk` rises.
  - `rx_data`=0xA5 with `rx_valid` 34 cycles after `chip_select` falls.
  - `chip_select` rises 2 cycles after the last `sclk` rise.
- **Two-word frame into `led_spi_slave`.** Send 0x01 (last=0) then 0x02 (last=1).
  - `chip_select` stays low across both words; 16 `sclk` rises in total.
  - Exactly two `rx_valid` pulses.
  - The slave's `led` output matches its response to the 0x01/0x02 command sequence.
- **Back-pressure.** Hold `tx_valid`=1 with a new `tx_data` during SHIFT.
  - `tx_ready`=0 and the word in flight is unchanged.
  - The second word is accepted only in WAIT or IDLE.
- **Reset mid-word.** Pull `reset`=0 after the 3rd `sclk` rise.
  - The next edge gives `chip_select`=1, `sclk`=1, `mosi`=0, `rx_valid`=0.
  - No `rx_valid` for the aborted word.
  - A fresh 0x3C word afterwards transfers correctly.
- **CLK_DIV=1.** Send 0xFF then 0x00 with `miso` tied to 1.
  - SCLK period is 2 cycles.
  - Both words give `rx_data`=0xFF.
  - `mosi` is all 1s, then all 0s.
- **Idle WAIT.** Send 0xF0 with last=0 and no follow-up word for 100 cycles.
  - `chip_select` stays 0, `sclk` stays 1, `tx_ready` stays 1.
  - A later word with last=1 closes the frame normally.
